// File: rtl/gecko_pkg.sv
// Shared types for the gecko fetch stage and its interface to gecko_decode.
package gecko_pkg;

  // Fetch FSM: one boot cycle, then issuing, then a terminal halted state.
  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } gecko_fetch_state_t;

  // Per-fetch record sent to decode alongside the memory read.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [0:0]  epoch;
  } gecko_instruction_operation_t;

  // Redirect request coming back from decode.
  typedef struct packed {
    logic        update_pc;
    logic [31:0] actual_next_pc;
  } gecko_jump_operation_t;

  // Width of the outstanding-fetch credit counter (holds up to 15).
  localparam int unsigned GECKO_CREDIT_W = 4;

  // Word-align an address by clearing its two low bits.
  function automatic logic [31:0] gecko_word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/gecko_fetch_fork.sv
// Two-way stream fork: one upstream valid drives two downstream sides, each
// side remembers whether it has already handshaken for the current item.
module gecko_fetch_fork (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic a_valid,
  input  logic a_ready,
  output logic b_valid,
  input  logic b_ready,
  output logic partial,
  output logic done
);

  logic a_sent_q;
  logic a_sent_d;
  logic b_sent_q;
  logic b_sent_d;
  logic a_hs;
  logic b_hs;

  // Side valids, handshakes, completion and next sent bits.
  always_comb begin
    a_valid  = in_valid & ~a_sent_q;
    b_valid  = in_valid & ~b_sent_q;
    a_hs     = a_valid & a_ready;
    b_hs     = b_valid & b_ready;
    partial  = a_sent_q | b_sent_q;
    done     = in_valid & (a_sent_q | a_hs) & (b_sent_q | b_hs);
    a_sent_d = a_sent_q;
    b_sent_d = b_sent_q;
    if (done) begin
      a_sent_d = 1'b0;
      b_sent_d = 1'b0;
    end else begin
      a_sent_d = a_sent_q | a_hs;
      b_sent_d = b_sent_q | b_hs;
    end
  end

  // Sent-bit registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sent_q <= 1'b0;
      b_sent_q <= 1'b0;
    end else begin
      a_sent_q <= a_sent_d;
      b_sent_q <= b_sent_d;
    end
  end

endmodule

// File: rtl/gecko_fetch_unit.sv
// Instruction fetch stage: owns the PC, epoch and credit counter, and issues
// each fetch as a forked pair (memory read + decode command) carrying the
// same PC and epoch. Redirects on decode's jump stream.
module gecko_fetch_unit
  import gecko_pkg::*;
#(
  parameter logic [31:0] START_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         jump_command_valid,
  output logic                         jump_command_ready,
  input  gecko_jump_operation_t        jump_command_data,
  input  logic                         instruction_decoded,
  input  logic                         halt,
  output logic                         instruction_request_valid,
  input  logic                         instruction_request_ready,
  output logic                         instruction_request_read_enable,
  output logic [3:0]                   instruction_request_write_enable,
  output logic [31:0]                  instruction_request_addr,
  output logic [31:0]                  instruction_request_data,
  output logic                         instruction_request_id,
  output logic                         instruction_request_last,
  output logic                         instruction_command_valid,
  input  logic                         instruction_command_ready,
  output gecko_instruction_operation_t instruction_command_data,
  output logic                         misaligned_jump_flag
);

  localparam logic [GECKO_CREDIT_W:0] MAX_CREDITS = MAX_OUTSTANDING[GECKO_CREDIT_W:0];
  localparam logic [GECKO_CREDIT_W:0] CREDIT_ONE  = {{GECKO_CREDIT_W{1'b0}}, 1'b1};

  gecko_fetch_state_t        state_q;
  gecko_fetch_state_t        state_d;
  logic [31:0]               pc_q;
  logic [31:0]               pc_d;
  logic                      epoch_q;
  logic                      epoch_d;
  logic [GECKO_CREDIT_W-1:0] credits_q;
  logic [GECKO_CREDIT_W-1:0] credits_d;
  logic                      misaligned_q;
  logic                      misaligned_d;

  logic                      fork_partial;
  logic                      fork_done;
  logic                      issue;
  logic                      jump_ready;
  logic                      jump_accept;
  logic                      redirect;
  logic [31:0]               pc_plus4;
  logic [GECKO_CREDIT_W:0]   credit_sum;

  // Issue/redirect arbitration. A started fork always runs to completion;
  // a new fork only starts with credit, no halt, and no jump being taken.
  always_comb begin
    jump_ready  = ((state_q == RUN) || (state_q == HALTED)) && !fork_partial;
    jump_accept = jump_command_valid && jump_ready;
    redirect    = jump_accept && jump_command_data.update_pc;
    issue       = (state_q == RUN) &&
                  (fork_partial || ((credits_q != '0) && !halt && !jump_accept));
    pc_plus4    = pc_q + 32'd4;
  end

  gecko_fetch_fork u_fork (
    .clk      (clk),
    .rst      (rst),
    .in_valid (issue),
    .a_valid  (instruction_request_valid),
    .a_ready  (instruction_request_ready),
    .b_valid  (instruction_command_valid),
    .b_ready  (instruction_command_ready),
    .partial  (fork_partial),
    .done     (fork_done)
  );

  // Payload is driven straight from registered state, so it cannot move
  // while either side of the fork is still waiting.
  always_comb begin
    jump_command_ready               = jump_ready;
    instruction_request_read_enable  = 1'b1;
    instruction_request_write_enable = 4'b0000;
    instruction_request_addr         = pc_q;
    instruction_request_data         = 32'd0;
    instruction_request_id           = epoch_q;
    instruction_request_last         = 1'b1;
    instruction_command_data.pc      = pc_q;
    instruction_command_data.next_pc = pc_plus4;
    instruction_command_data.epoch   = epoch_q;
    misaligned_jump_flag             = misaligned_q;
  end

  // Next-state for FSM, PC, epoch and the sticky misalignment flag.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    epoch_d      = epoch_q;
    misaligned_d = misaligned_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt && !fork_partial) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
    if (redirect) begin
      pc_d    = gecko_word_align(jump_command_data.actual_next_pc);
      epoch_d = ~epoch_q;
      if (jump_command_data.actual_next_pc[1:0] != 2'b00) misaligned_d = 1'b1;
    end else if (fork_done) begin
      pc_d = pc_plus4;
    end
  end

  // Credit return from decode and consumption by completed forks; surplus
  // returns beyond the configured limit are dropped.
  always_comb begin
    credit_sum = {1'b0, credits_q} + {{GECKO_CREDIT_W{1'b0}}, instruction_decoded};
    if (fork_done) credit_sum = credit_sum - CREDIT_ONE;
    if (credit_sum > MAX_CREDITS) credit_sum = MAX_CREDITS;
    credits_d = credit_sum[GECKO_CREDIT_W-1:0];
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      pc_q         <= START_ADDR;
      epoch_q      <= 1'b0;
      credits_q    <= MAX_CREDITS[GECKO_CREDIT_W-1:0];
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      epoch_q      <= epoch_d;
      credits_q    <= credits_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_gecko_fetch_unit.sv
// Self-checking bench for gecko_fetch_unit: directed scenarios plus a
// randomized run, all compared against a behavioural model of the fetch rules.
module tb_gecko_fetch_unit;
  import gecko_pkg::*;

  localparam logic [31:0] START = 32'h0000_0100;
  localparam int          MAXO  = 4;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         jump_valid;
  logic                         jump_ready;
  gecko_jump_operation_t        jump_data;
  logic                         decoded;
  logic                         halt;
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_re;
  logic [3:0]                   req_we;
  logic [31:0]                  req_addr;
  logic [31:0]                  req_data;
  logic                         req_id;
  logic                         req_last;
  logic                         cmd_valid;
  logic                         cmd_ready;
  gecko_instruction_operation_t cmd_data;
  logic                         mis;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gecko_fetch_unit #(.START_ADDR(START), .MAX_OUTSTANDING(MAXO)) dut (
    .clk                              (clk),
    .rst                              (rst),
    .jump_command_valid               (jump_valid),
    .jump_command_ready               (jump_ready),
    .jump_command_data                (jump_data),
    .instruction_decoded              (decoded),
    .halt                             (halt),
    .instruction_request_valid        (req_valid),
    .instruction_request_ready        (req_ready),
    .instruction_request_read_enable  (req_re),
    .instruction_request_write_enable (req_we),
    .instruction_request_addr         (req_addr),
    .instruction_request_data         (req_data),
    .instruction_request_id           (req_id),
    .instruction_request_last         (req_last),
    .instruction_command_valid        (cmd_valid),
    .instruction_command_ready        (cmd_ready),
    .instruction_command_data         (cmd_data),
    .misaligned_jump_flag             (mis)
  );

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc;
  logic        m_epoch;
  int          m_credits;
  logic        m_req_sent, m_cmd_sent, m_halted, m_mis, m_live;
  logic        m_partial, m_jrdy, m_jacc, m_issue, m_req_hs, m_cmd_hs, m_done;
  logic        exp_req_valid, exp_cmd_valid;
  int          m_credit_next;
  gecko_instruction_operation_t exp_cmd;

  always_comb begin
    m_partial     = m_req_sent || m_cmd_sent;
    m_jrdy        = m_live && !m_partial;
    m_jacc        = jump_valid && m_jrdy;
    m_issue       = m_live && !m_halted &&
                    (m_partial || (m_credits > 0 && !halt && !m_jacc));
    exp_req_valid = m_issue && !m_req_sent;
    exp_cmd_valid = m_issue && !m_cmd_sent;
    m_req_hs      = exp_req_valid && req_ready;
    m_cmd_hs      = exp_cmd_valid && cmd_ready;
    m_done        = (m_req_sent || m_req_hs) && (m_cmd_sent || m_cmd_hs);
    m_credit_next = m_credits - (m_done ? 1 : 0) + (decoded ? 1 : 0);
    if (m_credit_next > MAXO) m_credit_next = MAXO;
    exp_cmd.pc      = m_pc;
    exp_cmd.next_pc = m_pc + 32'd4;
    exp_cmd.epoch   = m_epoch;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc <= START; m_epoch <= 1'b0; m_credits <= MAXO;
      m_req_sent <= 1'b0; m_cmd_sent <= 1'b0; m_halted <= 1'b0;
      m_mis <= 1'b0; m_live <= 1'b0;
    end else begin
      m_live <= 1'b1;
      if (m_live) begin
        if (m_jacc && jump_data.update_pc) begin
          m_pc    <= {jump_data.actual_next_pc[31:2], 2'b00};
          m_epoch <= ~m_epoch;
          if (jump_data.actual_next_pc[1:0] != 2'b00) m_mis <= 1'b1;
        end else if (m_done) begin
          m_pc <= m_pc + 32'd4;
        end
        if (m_done) begin
          m_req_sent <= 1'b0; m_cmd_sent <= 1'b0;
        end else begin
          if (m_req_hs) m_req_sent <= 1'b1;
          if (m_cmd_hs) m_cmd_sent <= 1'b1;
        end
        m_credits <= m_credit_next;
        if (!m_halted && halt && !m_partial) m_halted <= 1'b1;
      end
    end
  end

  // Accepted transfers, as seen on the DUT ports.
  logic [31:0] req_log[$];
  logic [31:0] cmd_log[$];
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (req_valid && req_ready) req_log.push_back(req_addr);
      if (cmd_valid && cmd_ready) cmd_log.push_back(cmd_data.pc);
    end
  end

  // ---------------- timing / stimulus helpers ----------------
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rr, input logic cr, input logic dec, input logic hl,
                        input logic jv, input logic ju, input logic [31:0] jt);
    req_ready  = rr;
    cmd_ready  = cr;
    decoded    = dec;
    halt       = hl;
    jump_valid = jv;
    jump_data.update_pc      = ju;
    jump_data.actual_next_pc = jt;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_valid !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valids: got req=%b cmd=%b, expected 0/0", req_valid, cmd_valid);
    end
    n_checks++;
    if (jump_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_jump_ready: got %b, expected 0", jump_ready);
    end
    n_checks++;
    if (mis !== 1'b0) begin
      n_fail++; $display("FAIL reset_misaligned: got %b, expected 0", mis);
    end
    to_pos();
    to_pos();
    rst = 1'b1;
    req_log.delete();
    cmd_log.delete();
    to_neg();
    n_checks++;
    if (req_valid !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL boot_valids: got req=%b cmd=%b, expected 0/0", req_valid, cmd_valid);
    end
    n_checks++;
    if (req_re !== 1'b1 || req_we !== 4'h0 || req_data !== 32'd0 || req_last !== 1'b1) begin
      n_fail++; $display("FAIL const_outputs: got re=%b we=%h data=%h last=%b, expected 1/0/0/1",
                         req_re, req_we, req_data, req_last);
    end
    to_pos();
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== START || req_id !== 1'b0) begin
      n_fail++; $display("FAIL first_fetch: got v=%b addr=%h id=%b, expected 1/%h/0",
                         req_valid, req_addr, req_id, START);
    end
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_data !== exp_cmd) begin
      n_fail++; $display("FAIL first_cmd: got v=%b data=%h, expected 1/%h", cmd_valid, cmd_data, exp_cmd);
    end
    to_pos();
  endtask

  task automatic test_credit_limit();
    for (int c = 0; c < 10; c++) begin
      to_neg();
      n_checks++;
      if (req_valid !== exp_req_valid || (req_valid && req_addr !== m_pc)) begin
        n_fail++; $display("FAIL credit_limit_cycle%0d: got v=%b addr=%h, expected v=%b addr=%h",
                           c, req_valid, req_addr, exp_req_valid, m_pc);
      end
      to_pos();
    end
    n_checks++;
    if (req_log.size() != 4 || cmd_log.size() != 4) begin
      n_fail++; $display("FAIL credit_limit_count: got req=%0d cmd=%0d, expected 4/4",
                         req_log.size(), cmd_log.size());
    end
    for (int i = 0; i < 4 && i < req_log.size() && i < cmd_log.size(); i++) begin
      n_checks++;
      if (req_log[i] !== START + 32'(4 * i) || cmd_log[i] !== START + 32'(4 * i)) begin
        n_fail++; $display("FAIL credit_limit_addr%0d: got req=%h cmd=%h, expected %h",
                           i, req_log[i], cmd_log[i], START + 32'(4 * i));
      end
    end
    to_neg();
    n_checks++;
    if (req_valid !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL credit_limit_idle: got req=%b cmd=%b, expected 0/0", req_valid, cmd_valid);
    end
    to_pos();
  endtask

  task automatic test_decoded();
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    to_neg();
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_fail++; $display("FAIL decoded_pre: got v=%b, expected 0", req_valid);
    end
    to_pos();
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h110) begin
      n_fail++; $display("FAIL decoded_refetch: got v=%b addr=%h, expected 1/00000110", req_valid, req_addr);
    end
    to_pos();
    decoded = 1'b0;
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h114) begin
      n_fail++; $display("FAIL decoded_net_zero: got v=%b addr=%h, expected 1/00000114", req_valid, req_addr);
    end
    to_pos();
    to_neg();
    n_checks++;
    if (req_valid !== 1'b0) begin
      n_fail++; $display("FAIL decoded_exhausted: got v=%b, expected 0", req_valid);
    end
    to_pos();
  endtask

  task automatic test_backpressure();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int c = 0; c < 5; c++) begin
      to_neg();
      n_checks++;
      if (req_valid !== exp_req_valid || cmd_valid !== exp_cmd_valid) begin
        n_fail++; $display("FAIL refill_valids%0d: got %b/%b, expected %b/%b",
                           c, req_valid, cmd_valid, exp_req_valid, exp_cmd_valid);
      end
      to_pos();
    end
    req_log.delete();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h118) begin
      n_fail++; $display("FAIL bp_request: got v=%b addr=%h, expected 1/00000118", req_valid, req_addr);
    end
    to_pos();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3000);
    for (int c = 0; c < 2; c++) begin
      to_neg();
      n_checks++;
      if (req_valid !== 1'b0 || cmd_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_valids%0d: got req=%b cmd=%b, expected 0/1", c, req_valid, cmd_valid);
      end
      n_checks++;
      if (cmd_data.pc !== 32'h118 || cmd_data.next_pc !== 32'h11C || cmd_data.epoch !== 1'b0) begin
        n_fail++; $display("FAIL bp_payload%0d: got %h, expected pc=118 next=11c epoch=0", c, cmd_data);
      end
      n_checks++;
      if (jump_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_jump_ready%0d: got %b, expected 0", c, jump_ready);
      end
      to_pos();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    to_neg();
    n_checks++;
    if (cmd_valid !== 1'b1 || cmd_data.pc !== 32'h118) begin
      n_fail++; $display("FAIL bp_cmd_release: got v=%b pc=%h, expected 1/00000118", cmd_valid, cmd_data.pc);
    end
    to_pos();
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h11C) begin
      n_fail++; $display("FAIL bp_advance: got v=%b addr=%h, expected 1/0000011c", req_valid, req_addr);
    end
    n_checks++;
    if (req_log.size() != 1 || (req_log.size() > 0 && req_log[0] !== 32'h118)) begin
      n_fail++; $display("FAIL bp_single_request: got %0d requests, expected one at 00000118", req_log.size());
    end
    to_pos();
  endtask

  task automatic test_jump();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    to_pos();
    to_pos();
    req_log.delete();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
    to_neg();
    n_checks++;
    if (jump_ready !== 1'b1 || req_valid !== 1'b0) begin
      n_fail++; $display("FAIL jump_accept: got rdy=%b v=%b, expected 1/0", jump_ready, req_valid);
    end
    to_pos();
    jump_valid = 1'b0;
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h40 || req_id !== 1'b1) begin
      n_fail++; $display("FAIL jump_target40: got v=%b addr=%h id=%b, expected 1/00000040/1",
                         req_valid, req_addr, req_id);
    end
    to_pos();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h2000);
    to_neg();
    n_checks++;
    if (req_valid !== 1'b0 || jump_ready !== 1'b1) begin
      n_fail++; $display("FAIL jump_wins: got v=%b rdy=%b, expected 0/1", req_valid, jump_ready);
    end
    to_pos();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h2000 || req_id !== 1'b0 || cmd_data !== exp_cmd) begin
      n_fail++; $display("FAIL jump_target2000: got v=%b addr=%h id=%b, expected 1/00002000/0",
                         req_valid, req_addr, req_id);
    end
    to_pos();
    n_checks++;
    if (req_log.size() != 1 || (req_log.size() > 0 && req_log[0] !== 32'h2000)) begin
      n_fail++; $display("FAIL jump_no_stale: got %0d requests, expected only 00002000", req_log.size());
    end
  endtask

  task automatic test_misaligned();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2002);
    to_neg();
    n_checks++;
    if (jump_ready !== 1'b1 || mis !== 1'b0) begin
      n_fail++; $display("FAIL mis_accept: got rdy=%b flag=%b, expected 1/0", jump_ready, mis);
    end
    to_pos();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5000);
    to_neg();
    n_checks++;
    if (mis !== 1'b1 || jump_ready !== 1'b1) begin
      n_fail++; $display("FAIL mis_flag: got flag=%b rdy=%b, expected 1/1", mis, jump_ready);
    end
    to_pos();
    jump_valid = 1'b0;
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== 32'h2000 || req_id !== 1'b1) begin
      n_fail++; $display("FAIL mis_no_update: got v=%b addr=%h id=%b, expected 1/00002000/1",
                         req_valid, req_addr, req_id);
    end
    to_pos();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int c = 0; c < 3; c++) begin
      to_neg();
      n_checks++;
      if (mis !== 1'b1) begin
        n_fail++; $display("FAIL mis_sticky%0d: got %b, expected 1", c, mis);
      end
      to_pos();
    end
  endtask

  task automatic test_random();
    logic [31:0] jt;
    for (int c = 0; c < 2000; c++) begin
      jt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom();
      if ($urandom_range(0, 4) != 0) jt[1:0] = 2'b00;
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
             1'b0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, jt);
      to_neg();
      n_checks++;
      if (req_valid !== exp_req_valid || cmd_valid !== exp_cmd_valid || jump_ready !== m_jrdy) begin
        n_fail++; $display("FAIL rand_ctrl%0d: got req=%b cmd=%b jrdy=%b, expected %b/%b/%b",
                           c, req_valid, cmd_valid, jump_ready, exp_req_valid, exp_cmd_valid, m_jrdy);
      end
      if (req_valid && (req_addr !== m_pc || req_id !== m_epoch)) begin
        n_checks++; n_fail++;
        $display("FAIL rand_req%0d: got addr=%h id=%b, expected %h/%b", c, req_addr, req_id, m_pc, m_epoch);
      end
      if (cmd_valid && cmd_data !== exp_cmd) begin
        n_checks++; n_fail++;
        $display("FAIL rand_cmd%0d: got %h, expected %h", c, cmd_data, exp_cmd);
      end
      if (mis !== m_mis) begin
        n_checks++; n_fail++;
        $display("FAIL rand_mis%0d: got %b, expected %b", c, mis, m_mis);
      end
      to_pos();
    end
  endtask

  task automatic test_halt_reset();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    to_pos();
    to_pos();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int c = 0; c < 4; c++) to_pos();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || req_valid !== exp_req_valid) begin
      n_fail++; $display("FAIL halt_start: got v=%b, expected 1", req_valid);
    end
    to_pos();
    halt = 1'b1;
    to_neg();
    n_checks++;
    if (cmd_valid !== 1'b1 || req_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_midfork: got req=%b cmd=%b, expected 0/1", req_valid, cmd_valid);
    end
    to_pos();
    cmd_ready = 1'b1;
    to_neg();
    n_checks++;
    if (cmd_valid !== 1'b1) begin
      n_fail++; $display("FAIL halt_complete: got cmd=%b, expected 1", cmd_valid);
    end
    to_pos();
    for (int c = 0; c < 6; c++) begin
      if (c >= 3) halt = 1'b0;
      to_neg();
      n_checks++;
      if (req_valid !== 1'b0 || cmd_valid !== 1'b0) begin
        n_fail++; $display("FAIL halted_idle%0d: got req=%b cmd=%b, expected 0/0", c, req_valid, cmd_valid);
      end
      to_pos();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    to_pos();
    rst = 1'b1;
    to_pos();
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== START) begin
      n_fail++; $display("FAIL restart_fetch: got v=%b addr=%h, expected 1/%h", req_valid, req_addr, START);
    end
    to_pos();
    #2;
    n_checks++;
    if (cmd_valid !== 1'b1 || req_valid !== 1'b0) begin
      n_fail++; $display("FAIL pre_async_reset: got req=%b cmd=%b, expected 0/1", req_valid, cmd_valid);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_valid !== 1'b0 || cmd_valid !== 1'b0 || mis !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got req=%b cmd=%b flag=%b, expected 0/0/0",
                         req_valid, cmd_valid, mis);
    end
    to_pos();
    rst = 1'b1;
    to_neg();
    n_checks++;
    if (req_valid !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reboot_boot: got req=%b cmd=%b, expected 0/0", req_valid, cmd_valid);
    end
    to_pos();
    to_neg();
    n_checks++;
    if (req_valid !== 1'b1 || cmd_valid !== 1'b1 || req_addr !== START || req_id !== 1'b0) begin
      n_fail++; $display("FAIL reboot_fetch: got req=%b cmd=%b addr=%h id=%b, expected 1/1/%h/0",
                         req_valid, cmd_valid, req_addr, req_id, START);
    end
    to_pos();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_credit_limit();
    test_decoded();
    test_backpressure();
    test_jump();
    test_misaligned();
    test_random();
    test_halt_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
